// File: rtl/usb_tx_packet_ctrl_if.sv
// Packet-transmit bundle between usb_tx_packet_ctrl (master), the packet buffer and the bit serializer.
// byte stream: a byte moves on a rising clk edge when byte_valid && byte_ready. Once byte_valid rises,
// byte_out/eop hold and byte_valid stays high until that transfer happens.
interface usb_tx_packet_ctrl_if;
  logic [2:0] TX_Packet;
  logic [6:0] Buffer_Occupancy;
  logic [7:0] TX_Packet_Data;
  logic       Get_TX_Packet_Data;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       eop;
  logic       TX_Transfer_Active;
  logic       TX_Error;

  modport master (
    input  TX_Packet, Buffer_Occupancy, TX_Packet_Data, byte_ready,
    output Get_TX_Packet_Data, byte_out, byte_valid, eop, TX_Transfer_Active, TX_Error
  );

  modport slave (
    output TX_Packet, Buffer_Occupancy, TX_Packet_Data, byte_ready,
    input  Get_TX_Packet_Data, byte_out, byte_valid, eop, TX_Transfer_Active, TX_Error
  );
endinterface

// File: rtl/usb_tx_packet_ctrl.sv
// USB packet transmit sequencer: SYNC, PID, buffered payload and optional CRC16 as a byte stream.
// Define USB_TX_CRC_EN to append the CRC_LO/CRC_HI bytes to DATA packets.
module usb_tx_packet_ctrl (
  input  logic                        clk,
  input  logic                        n_rst,
  usb_tx_packet_ctrl_if.master        bus,
  output logic [2:0]                  state_dbg
);
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_FETCH, S_LOAD, S_DATA, S_CRC_LO, S_CRC_HI
  } state_t;

  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;

`ifdef USB_TX_CRC_EN
  localparam state_t DONE_STATE = S_CRC_LO;
`else
  localparam state_t DONE_STATE = S_IDLE;
`endif

  state_t     state, state_n;
  logic [2:0] pkt_type;
  logic [6:0] count;
  logic [7:0] data_q;
  logic       tx_error_q;
  logic       xfer, is_data, req_data, req_bad, req_ok;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign is_data   = (pkt_type == PKT_DATA0) || (pkt_type == PKT_DATA1);
  assign req_data  = (bus.TX_Packet == PKT_DATA0) || (bus.TX_Packet == PKT_DATA1);
  assign req_bad   = (bus.TX_Packet >= 3'd6) || (req_data && (bus.Buffer_Occupancy > 7'd64));
  assign req_ok    = (bus.TX_Packet != 3'd0) && !req_bad;
  assign state_dbg = state;

  function automatic logic [7:0] pid_byte(input logic [2:0] t);
    case (t)
      PKT_DATA0: pid_byte = 8'hC3;
      PKT_DATA1: pid_byte = 8'h4B;
      PKT_ACK:   pid_byte = 8'hD2;
      PKT_NAK:   pid_byte = 8'h5A;
      default:   pid_byte = 8'h1E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (req_ok) state_n = S_SYNC;
      S_SYNC:   if (xfer) state_n = S_PID;
      S_PID:    if (xfer) begin
                  if (!is_data)        state_n = S_IDLE;
                  else if (count != 0) state_n = S_FETCH;
                  else                 state_n = DONE_STATE;
                end
      S_FETCH:  state_n = S_LOAD;
      S_LOAD:   state_n = S_DATA;
      S_DATA:   if (xfer) state_n = (count != 0) ? S_FETCH : DONE_STATE;
      S_CRC_LO: if (xfer) state_n = S_CRC_HI;
      S_CRC_HI: if (xfer) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Count is the number of pops still owed; it drops in FETCH so DATA sees the post-pop value.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      pkt_type   <= 3'd0;
      count      <= 7'd0;
      data_q     <= 8'h00;
      tx_error_q <= 1'b0;
    end else begin
      tx_error_q <= (state == S_IDLE) && req_bad;
      if ((state == S_IDLE) && req_ok) begin
        pkt_type <= bus.TX_Packet;
        count    <= req_data ? bus.Buffer_Occupancy : 7'd0;
      end
      if (state == S_FETCH) count  <= count - 7'd1;
      if (state == S_LOAD)  data_q <= bus.TX_Packet_Data;
    end
  end

`ifdef USB_TX_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst)                        crc <= 16'hFFFF;
    else if (state == S_IDLE)         crc <= 16'hFFFF;
    else if ((state == S_DATA) && xfer) crc <= crc16_byte(crc, data_q);
  end
`endif

  always_comb begin
    bus.byte_out           = 8'h00;
    bus.byte_valid         = 1'b0;
    bus.eop                = 1'b0;
    bus.Get_TX_Packet_Data = (state == S_FETCH);
    bus.TX_Transfer_Active = (state != S_IDLE);
    bus.TX_Error           = tx_error_q;
    case (state)
      S_SYNC: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = 8'h80;
      end
      S_PID: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = pid_byte(pkt_type);
`ifdef USB_TX_CRC_EN
        bus.eop        = !is_data;
`else
        bus.eop        = !is_data || (count == 7'd0);
`endif
      end
      S_DATA: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = data_q;
`ifndef USB_TX_CRC_EN
        bus.eop        = (count == 7'd0);
`endif
      end
`ifdef USB_TX_CRC_EN
      S_CRC_LO: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = ~crc[7:0];
      end
      S_CRC_HI: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = ~crc[15:8];
        bus.eop        = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Bench for usb_tx_packet_ctrl: packet-level byte model, buffer responder, random serializer backpressure.
module tb_usb_tx_packet_ctrl;
  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] state_dbg;

  usb_tx_packet_ctrl_if bus();

  usb_tx_packet_ctrl dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];   // {eop, byte} in transmit order
  logic [8:0] got_q[$];
  logic [7:0] buf_q[$];
  int pop_cnt = 0, bad_pops = 0, xfer_cnt = 0, err_cnt = 0, valid_cycles = 0;
  int ready_mode = 0;     // 0 always ready, 1 random, 2 three-cycle stall per byte
  int wait_cnt = 0;
  logic prev_stall = 1'b0;
  logic [8:0] held = '0;
  logic rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc16_usb(input logic [7:0] d[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (d[i]) begin
      c = c ^ {8'h00, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [7:0] pid_of(input logic [2:0] t);
    logic [7:0] tbl [0:7];
    tbl = '{8'h00, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'h00, 8'h00};
    return tbl[t];
  endfunction

  // Buffer: registered read data, valid the cycle after the pop strobe.
  always @(posedge clk) begin
    if (!n_rst && bus.Get_TX_Packet_Data) begin
      pop_cnt++;
      if (buf_q.size() == 0) bad_pops++;
      else bus.TX_Packet_Data <= buf_q.pop_front();
    end
  end

  // Serializer side: drives byte_ready and scores every transfer against the model queue.
  always @(negedge clk) begin
    if (n_rst) begin
      prev_stall = 1'b0;
      wait_cnt = 0;
      bus.byte_ready = 1'b0;
    end else begin
      if (bus.byte_valid) valid_cycles++;
      if (bus.TX_Error) err_cnt++;
      if (bus.Get_TX_Packet_Data) check("pop_outside_packet", bus.TX_Transfer_Active, 1);
      if (prev_stall) check("stall_hold", {bus.byte_valid, bus.eop, bus.byte_out}, {1'b1, held});
      if (bus.byte_valid) begin
        check("valid_implies_active", bus.TX_Transfer_Active, 1);
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 3) != 0);
          default: rdy = (wait_cnt >= 3);
        endcase
        wait_cnt = rdy ? 0 : wait_cnt + 1;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      bus.byte_ready = rdy;
      if (bus.byte_valid && rdy) begin
        xfer_cnt++;
        got_q.push_back({bus.eop, bus.byte_out});
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", {bus.eop, bus.byte_out});
        end else begin
          check("byte_stream", {bus.eop, bus.byte_out}, exp_q.pop_front());
        end
      end
      prev_stall = bus.byte_valid && !rdy;
      held = {bus.eop, bus.byte_out};
    end
  end

  task automatic build_exp(input logic [2:0] t, input logic [7:0] d[$]);
    logic [15:0] c;
    int n = d.size();
    exp_q.push_back(9'h080);
    if (t >= 3'd3) begin
      exp_q.push_back({1'b1, pid_of(t)});
      return;
    end
`ifdef USB_TX_CRC_EN
    exp_q.push_back({1'b0, pid_of(t)});
    foreach (d[i]) exp_q.push_back({1'b0, d[i]});
    c = crc16_usb(d);
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back({1'b1, c[15:8]});
`else
    c = 16'h0;
    exp_q.push_back({n == 0, pid_of(t)});
    foreach (d[i]) exp_q.push_back({i == n - 1, d[i]});
`endif
  endtask

  task automatic run_pkt(input logic [2:0] t, input logic [7:0] d[$], input int mode, input bit junk);
    int p0, x0, exp_len, cyc;
    bit is_data = (t == 3'd1) || (t == 3'd2);
    got_q.delete();
    exp_q.delete();
    buf_q.delete();
    ready_mode = mode;
    if (is_data) buf_q = d;
    build_exp(t, is_data ? d : buf_q);
    exp_len = exp_q.size();
    p0 = pop_cnt;
    x0 = xfer_cnt;
    @(negedge clk);
    bus.TX_Packet = t;
    bus.Buffer_Occupancy = is_data ? 7'(d.size()) : 7'($urandom_range(0, 127));
    @(negedge clk);
    bus.TX_Packet = 3'd0;
    check("request_accepted", bus.TX_Transfer_Active, 1);
    cyc = 0;
    while (bus.TX_Transfer_Active && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (junk && bus.TX_Transfer_Active) begin
        bus.TX_Packet = 3'($urandom_range(0, 7));
        bus.Buffer_Occupancy = 7'($urandom_range(0, 127));
      end else begin
        bus.TX_Packet = 3'd0;
      end
    end
    bus.TX_Packet = 3'd0;
    if (cyc >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL packet_timeout: type %0d still active after %0d cycles", t, cyc);
    end
    check("model_drained", exp_q.size(), 0);
    check("pop_count", pop_cnt - p0, is_data ? d.size() : 0);
    check("byte_count", xfer_cnt - x0, exp_len);
    check("no_empty_pops", bad_pops, 0);
    exp_q.delete();
  endtask

  task automatic run_err(input logic [2:0] t, input logic [6:0] occ);
    int e0 = err_cnt, v0 = valid_cycles, p0 = pop_cnt;
    @(negedge clk);
    bus.TX_Packet = t;
    bus.Buffer_Occupancy = occ;
    @(negedge clk);
    bus.TX_Packet = 3'd0;
    check("reject_not_active", bus.TX_Transfer_Active, 0);
    repeat (4) @(negedge clk);
    check("error_pulse_count", err_cnt - e0, 1);
    check("reject_no_bytes", valid_cycles - v0, 0);
    check("reject_no_pops", pop_cnt - p0, 0);
  endtask

  initial begin
    logic [7:0] d[$];
    int cyc;
    n_rst = 1'b1;
    bus.TX_Packet = 3'd0;
    bus.Buffer_Occupancy = 7'd0;
    repeat (2) @(negedge clk);
    check("rst_byte_out", bus.byte_out, 8'h00);
    check("rst_byte_valid", bus.byte_valid, 0);
    check("rst_eop", bus.eop, 0);
    check("rst_get", bus.Get_TX_Packet_Data, 0);
    check("rst_active", bus.TX_Transfer_Active, 0);
    check("rst_error", bus.TX_Error, 0);
    n_rst = 1'b0;

    // Model pins: CRC-16/USB check value and the ACK byte pair.
    d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_123456789", crc16_usb(d), 16'hB4C8);

    d.delete();
    run_pkt(3'd3, d, 0, 0);
    check("ack_len", got_q.size(), 2);
    check("ack_sync", got_q[0], 9'h080);
    check("ack_pid_eop", got_q[1], 9'h1D2);

    d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_pkt(3'd1, d, 0, 0);
    check("data0_pid", got_q[1], 9'h0C3);
`ifdef USB_TX_CRC_EN
    check("data0_crc_lo", got_q[11], 9'h0C8);
    check("data0_crc_hi", got_q[12], 9'h1B4);
`else
    check("data0_last_eop", got_q[10], 9'h139);
`endif

    d.delete();
    run_pkt(3'd2, d, 0, 0);
`ifdef USB_TX_CRC_EN
    check("zlp_len", got_q.size(), 4);
    check("zlp_crc_hi", got_q[3], 9'h100);
`else
    check("zlp_pid_eop", got_q[1], 9'h14B);
`endif

    d = '{8'hA5, 8'h01, 8'h7E, 8'hFF};
    run_pkt(3'd1, d, 2, 0);

    run_err(3'd7, 7'd0);
    run_err(3'd1, 7'd65);
    run_err(3'd6, 7'd10);
    run_err(3'd2, 7'd127);

    // Reset in the middle of an 8-byte DATA0 right after its second payload byte moves.
    d.delete();
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom_range(0, 255)));
    got_q.delete();
    exp_q.delete();
    buf_q = d;
    ready_mode = 0;
    build_exp(3'd1, d);
    cyc = pop_cnt;
    @(negedge clk);
    bus.TX_Packet = 3'd1;
    bus.Buffer_Occupancy = 7'd8;
    @(negedge clk);
    bus.TX_Packet = 3'd0;
    for (int i = 0; i < 200 && got_q.size() < 4; i++) @(posedge clk);
    check("abort_reached_byte2", got_q.size(), 4);
    #1 n_rst = 1'b1;
    #1;
    check("abort_byte_valid", bus.byte_valid, 0);
    check("abort_byte_out", bus.byte_out, 8'h00);
    check("abort_get", bus.Get_TX_Packet_Data, 0);
    check("abort_active", bus.TX_Transfer_Active, 0);
    check("abort_eop", bus.eop, 0);
    check("abort_pops", pop_cnt - cyc, 2);
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    d.delete();
    run_pkt(3'd3, d, 1, 0);
    check("post_abort_ack", got_q[1], 9'h1D2);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) run_err(3'($urandom_range(6, 7)), 7'($urandom_range(0, 127)));
        else run_err(3'($urandom_range(1, 2)), 7'($urandom_range(65, 127)));
      end else begin
        d.delete();
        for (int i = $urandom_range(0, 64); i > 0; i--) d.push_back(8'($urandom_range(0, 255)));
        run_pkt(3'($urandom_range(1, 5)), d, $urandom_range(0, 2), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
